// File: rtl/snax_hwpe_regfile_pkg.sv
// -----------------------------------------------------------------------------
// snax_hwpe_regfile_pkg
// Shared definitions for the SNAX HWPE peripheral register file:
//   - word-index constants of the register map (byte address >> 2)
//   - job FSM state encoding
//   - STATUS register bit positions
//   - byte-enable merge helper
// -----------------------------------------------------------------------------
package snax_hwpe_regfile_pkg;

  // Register map, expressed as word index (add[7:2])
  localparam logic [5:0] TriggerAddr = 6'd0;
  localparam logic [5:0] StatusAddr  = 6'd1;
  localparam logic [5:0] ClearAddr   = 6'd2;
  localparam logic [5:0] CntAddr     = 6'd3;
  localparam logic [5:0] JobBase     = 6'd16;

  // STATUS layout: busy flag in bit 0, done counter starting at bit 8
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusCntLsb  = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } job_state_t;

  // Merge wdata into old_val for every byte lane whose enable is set
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/snax_hwpe_periph_regfile_if.sv
// -----------------------------------------------------------------------------
// snax_hwpe_periph_regfile_if
// 32-bit HWPE periph bus: request channel (req/gnt/add/wen/be/data/id) and
// response channel (r_valid/r_data/r_id).
//   master modport : the controller issuing transactions
//   slave modport  : the register file answering them
// wen = 1 means read, wen = 0 means write.
// -----------------------------------------------------------------------------
interface snax_hwpe_periph_regfile_if #(
  parameter int unsigned IdWidth = 5
) ();

  logic               req;
  logic               gnt;
  logic [31:0]        add;
  logic               wen;
  logic [3:0]         be;
  logic [31:0]        data;
  logic [IdWidth-1:0] id;
  logic [31:0]        r_data;
  logic               r_valid;
  logic [IdWidth-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );

endinterface

// File: rtl/snax_hwpe_periph_resp.sv
// -----------------------------------------------------------------------------
// snax_hwpe_periph_resp
// Grant / response stage of a periph target. A request is granted only while
// no response is outstanding, so a requester holding req high until r_valid
// is never accepted twice; throughput is one transaction every two cycles.
// An accepted request produces r_valid one cycle later with the captured id
// and data; r_id/r_data are zero whenever r_valid is low.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req_i, gnt_o    request valid / combinational grant
//   accept_o        request accepted this cycle (req & gnt)
//   id_i, rdata_i   id and response data captured on accept
//   r_valid_o, r_id_o, r_data_o  registered response
// -----------------------------------------------------------------------------
module snax_hwpe_periph_resp #(
  parameter int unsigned IdWidth = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  output logic               accept_o,
  input  logic [IdWidth-1:0] id_i,
  input  logic [31:0]        rdata_i,
  output logic               r_valid_o,
  output logic [IdWidth-1:0] r_id_o,
  output logic [31:0]        r_data_o
);

  logic               r_valid_r;
  logic [IdWidth-1:0] r_id_r;
  logic [31:0]        r_data_r;

  assign gnt_o    = req_i & ~r_valid_r;
  assign accept_o = gnt_o;

  // Response register: loaded on accept, cleared otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_r <= 1'b0;
      r_id_r    <= {IdWidth{1'b0}};
      r_data_r  <= 32'd0;
    end else if (accept_o) begin
      r_valid_r <= 1'b1;
      r_id_r    <= id_i;
      r_data_r  <= rdata_i;
    end else begin
      r_valid_r <= 1'b0;
      r_id_r    <= {IdWidth{1'b0}};
      r_data_r  <= 32'd0;
    end
  end

  assign r_valid_o = r_valid_r;
  assign r_id_o    = r_id_r;
  assign r_data_o  = r_data_r;

endmodule

// File: rtl/snax_hwpe_periph_regfile.sv
// -----------------------------------------------------------------------------
// snax_hwpe_periph_regfile
// Periph-bus register file of one SNAX HWPE accelerator: TRIGGER, STATUS,
// SOFT_CLEAR, DONE_CNT control registers plus NumJobRegs job registers at
// word index 16+. Issues a one-cycle start pulse to the engine, tracks the
// job with an IDLE/RUNNING FSM, counts completed jobs (saturating) and raises
// a one-cycle completion event.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   periph          periph bus, slave side
//   cfg_o           job registers flattened, register k at [32k+31:32k]
//   start_o         one-cycle job start pulse
//   done_i          one-cycle job completion pulse from the engine
//   busy_o          job in progress
//   evt_o           one-cycle completion event
// Build option SNAX_HWPE_REGFILE_SHADOW_EN: job registers are double-buffered;
// bus accesses use the shadow copy (writable while RUNNING), cfg_o shows the
// active copy, refreshed from the shadow when the job is started.
// -----------------------------------------------------------------------------
module snax_hwpe_periph_regfile
  import snax_hwpe_regfile_pkg::*;
#(
  parameter int unsigned NumJobRegs = 8,
  parameter int unsigned IdWidth    = 5,
  parameter int unsigned CntWidth   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  snax_hwpe_periph_regfile_if.slave periph,
  output logic [NumJobRegs*32-1:0] cfg_o,
  output logic                     start_o,
  input  logic                     done_i,
  output logic                     busy_o,
  output logic                     evt_o
);

  localparam int unsigned JobIdxW = (NumJobRegs > 1) ? $clog2(NumJobRegs) : 1;
  localparam logic [5:0]  JobEnd  = JobBase + 6'(NumJobRegs);

  logic [5:0]          word_idx_s;
  logic [5:0]          job_off_s;
  logic [JobIdxW-1:0]  job_idx_s;
  logic                job_hit_s;
  logic                accept_s;
  logic                wr_s;
  logic                trig_wr_s;
  logic                clr_wr_s;
  logic                cnt_wr_s;
  logic                job_wr_s;
  logic                done_ev_s;
  logic [31:0]         status_s;
  logic [31:0]         rdata_s;
  logic                unused_s;

  job_state_t          state_r, state_next_s;
  logic [CntWidth-1:0] cnt_r, cnt_next_s;
  logic                start_r, start_next_s;
  logic                evt_r, evt_next_s;

  // ---------------------------------------------------------------------------
  // Grant / response stage
  // ---------------------------------------------------------------------------
  snax_hwpe_periph_resp #(
    .IdWidth (IdWidth)
  ) i_resp (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (periph.req),
    .gnt_o     (periph.gnt),
    .accept_o  (accept_s),
    .id_i      (periph.id),
    .rdata_i   (rdata_s),
    .r_valid_o (periph.r_valid),
    .r_id_o    (periph.r_id),
    .r_data_o  (periph.r_data)
  );

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign word_idx_s = periph.add[7:2];
  assign job_off_s  = word_idx_s - JobBase;
  assign job_idx_s  = job_off_s[JobIdxW-1:0];
  assign job_hit_s  = (word_idx_s >= JobBase) && (word_idx_s < JobEnd);

  assign wr_s      = accept_s & ~periph.wen;
  assign trig_wr_s = wr_s & (word_idx_s == TriggerAddr) & (periph.be != 4'b0000);
  assign clr_wr_s  = wr_s & (word_idx_s == ClearAddr);
  assign cnt_wr_s  = wr_s & (word_idx_s == CntAddr);
  assign job_wr_s  = wr_s & job_hit_s;

  // Address bits outside the word index carry no meaning here
  assign unused_s = ^{periph.add[31:8], periph.add[1:0], job_off_s[5:JobIdxW]};

  // ---------------------------------------------------------------------------
  // Job registers
  // ---------------------------------------------------------------------------
`ifdef SNAX_HWPE_REGFILE_SHADOW_EN
  logic [31:0] shadow_r [NumJobRegs];
  logic [31:0] active_r [NumJobRegs];

  // Shadow takes every bus write; active copy is refreshed on job start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumJobRegs; k++) begin
        shadow_r[k] <= 32'd0;
        active_r[k] <= 32'd0;
      end
    end else if (clr_wr_s) begin
      for (int k = 0; k < NumJobRegs; k++) begin
        shadow_r[k] <= 32'd0;
        active_r[k] <= 32'd0;
      end
    end else begin
      if (job_wr_s) begin
        shadow_r[job_idx_s] <= apply_be(shadow_r[job_idx_s], periph.data, periph.be);
      end
      if (start_next_s) begin
        active_r <= shadow_r;
      end
    end
  end

  for (genvar k = 0; k < NumJobRegs; k++) begin : g_cfg
    assign cfg_o[32*k +: 32] = active_r[k];
  end
`else
  logic [31:0] job_r [NumJobRegs];

  // Single copy; locked against bus writes while a job runs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumJobRegs; k++) begin
        job_r[k] <= 32'd0;
      end
    end else if (clr_wr_s) begin
      for (int k = 0; k < NumJobRegs; k++) begin
        job_r[k] <= 32'd0;
      end
    end else if (job_wr_s && (state_r == IDLE)) begin
      job_r[job_idx_s] <= apply_be(job_r[job_idx_s], periph.data, periph.be);
    end
  end

  for (genvar k = 0; k < NumJobRegs; k++) begin : g_cfg
    assign cfg_o[32*k +: 32] = job_r[k];
  end
`endif

  // ---------------------------------------------------------------------------
  // Job FSM and done counter
  // ---------------------------------------------------------------------------

  // Next-state logic; a SOFT_CLEAR write overrides any coinciding done_i
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    start_next_s = 1'b0;
    evt_next_s   = 1'b0;
    done_ev_s    = 1'b0;
    if (clr_wr_s) begin
      state_next_s = IDLE;
      cnt_next_s   = {CntWidth{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_wr_s) begin
            state_next_s = RUNNING;
            start_next_s = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end
        RUNNING: begin
          // A trigger arriving now is ignored, even together with done_i
          if (done_i) begin
            state_next_s = IDLE;
            evt_next_s   = 1'b1;
            done_ev_s    = 1'b1;
          end else begin
            state_next_s = RUNNING;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
      // A DONE_CNT write wins over a simultaneous increment
      if (cnt_wr_s) begin
        cnt_next_s = {CntWidth{1'b0}};
      end else if (done_ev_s && (cnt_r != {CntWidth{1'b1}})) begin
        cnt_next_s = cnt_r + {{(CntWidth-1){1'b0}}, 1'b1};
      end else begin
        cnt_next_s = cnt_r;
      end
    end
  end

  // FSM state, counter and pulse outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= {CntWidth{1'b0}};
      start_r <= 1'b0;
      evt_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      start_r <= start_next_s;
      evt_r   <= evt_next_s;
    end
  end

  assign start_o = start_r;
  assign evt_o   = evt_r;
  assign busy_o  = (state_r == RUNNING);

  // ---------------------------------------------------------------------------
  // Read data mux (sampled by the response stage on accept)
  // ---------------------------------------------------------------------------

  // Register value for the addressed word; writes return zero
  always_comb begin
    status_s                            = 32'd0;
    status_s[StatusBusyBit]             = busy_o;
    status_s[StatusCntLsb +: CntWidth]  = cnt_r;
    rdata_s                             = 32'd0;
    if (periph.wen) begin
      case (word_idx_s)
        StatusAddr: rdata_s = status_s;
        CntAddr:    rdata_s = 32'(cnt_r);
        default: begin
          if (job_hit_s) begin
`ifdef SNAX_HWPE_REGFILE_SHADOW_EN
            rdata_s = shadow_r[job_idx_s];
`else
            rdata_s = job_r[job_idx_s];
`endif
          end else begin
            rdata_s = 32'd0;
          end
        end
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// -----------------------------------------------------------------------------
// tb_snax_hwpe_periph_regfile
// Directed and random periph traffic against a behavioural model of the
// register file. Expected responses are queued when a request is granted and
// a separate monitor compares them when r_valid appears.
// -----------------------------------------------------------------------------
module tb_snax_hwpe_periph_regfile;

  localparam int NJ   = 8;
  localparam int IDW  = 5;
  localparam int CW   = 8;
  localparam int CFGW = NJ * 32;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SNAX_HWPE_REGFILE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [CFGW-1:0] cfg;
  logic            start, done, busy, evt;

  always #5 clk = ~clk;

  snax_hwpe_periph_regfile_if #(.IdWidth(IDW)) periph_if ();

  snax_hwpe_periph_regfile #(
    .NumJobRegs (NJ),
    .IdWidth    (IDW),
    .CntWidth   (CW)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .periph  (periph_if),
    .cfg_o   (cfg),
    .start_o (start),
    .done_i  (done),
    .busy_o  (busy),
    .evt_o   (evt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
  } resp_t;
  resp_t exp_q[$];

  // Reference model: bus-visible copy, engine-visible copy, job flag, counter
  logic [31:0] m_job [NJ];
  logic [31:0] m_act [NJ];
  bit          m_run;
  int          m_cnt;

  task automatic check(input string name, input logic [CFGW-1:0] act, input logic [CFGW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [CFGW-1:0] exp_cfg();
    logic [CFGW-1:0] v;
    for (int k = 0; k < NJ; k++) v[32*k +: 32] = SHADOW ? m_act[k] : m_job[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NJ; k++) begin
      m_job[k] = 32'd0;
      m_act[k] = 32'd0;
    end
    m_run = 1'b0;
    m_cnt = 0;
  endtask

  // One accepted transaction plus an optional coinciding done pulse
  task automatic model_xact(input logic [31:0] addr, input logic wen, input logic [3:0] be,
                            input logic [31:0] data, input bit done_in,
                            output logic [31:0] rd, output bit es, output bit ee);
    int w;
    bit was_run;
    w  = int'(addr[7:2]);
    rd = 32'd0;
    es = 1'b0;
    ee = 1'b0;
    if (wen) begin
      if (w == 1) rd = 32'(m_cnt * 256 + int'(m_run));
      else if (w == 3) rd = 32'(m_cnt);
      else if (w >= 16 && w < 16 + NJ) rd = m_job[w - 16];
    end
    if (!wen && w == 2) begin
      model_reset();
      return;
    end
    was_run = m_run;
    if (done_in && was_run) begin
      m_run = 1'b0;
      if (m_cnt < CMAX) m_cnt++;
      ee = 1'b1;
    end
    if (!wen) begin
      if (w == 0 && be != 4'd0 && !was_run) begin
        m_run = 1'b1;
        es    = 1'b1;
        if (SHADOW) m_act = m_job;
      end
      if (w == 3) m_cnt = 0;
      if (w >= 16 && w < 16 + NJ && (SHADOW || !was_run)) m_job[w - 16] = merge(m_job[w - 16], data, be);
    end
  endtask

  // Issue one transaction at a negedge and check the side outputs
  task automatic xact(input logic [31:0] addr, input logic wen, input logic [3:0] be,
                      input logic [31:0] data, input bit done_in);
    logic [31:0] rd;
    bit es, ee;
    int budget;
    @(negedge clk);
    periph_if.req  = 1'b1;
    periph_if.add  = addr;
    periph_if.wen  = wen;
    periph_if.be   = be;
    periph_if.data = data;
    periph_if.id   = IDW'($urandom_range(0, 31));
    done           = done_in;
    #1;
    budget = 0;
    while (!periph_if.gnt && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!periph_if.gnt) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout addr %0h got no grant expected grant", addr);
      periph_if.req = 1'b0;
      done          = 1'b0;
      return;
    end
    model_xact(addr, wen, be, data, done_in, rd, es, ee);
    exp_q.push_back({periph_if.id, rd});
    @(negedge clk);
    periph_if.req = 1'b0;
    done          = 1'b0;
    check("start_pulse", CFGW'(start), CFGW'(es));
    check("evt_pulse", CFGW'(evt), CFGW'(ee));
    check("busy", CFGW'(busy), CFGW'(m_run));
    check("cfg", cfg, exp_cfg());
    @(negedge clk);
    check("start_low", CFGW'(start), CFGW'(0));
    check("evt_low", CFGW'(evt), CFGW'(0));
  endtask

  // Engine completion pulse without bus traffic
  task automatic pulse_done();
    bit ee;
    @(negedge clk);
    done = 1'b1;
    ee   = m_run;
    if (m_run) begin
      m_run = 1'b0;
      if (m_cnt < CMAX) m_cnt++;
    end
    @(negedge clk);
    done = 1'b0;
    check("done_evt", CFGW'(evt), CFGW'(ee));
    check("done_busy", CFGW'(busy), CFGW'(m_run));
    @(negedge clk);
    check("done_evt_low", CFGW'(evt), CFGW'(0));
  endtask

  // Response monitor: pops the scoreboard whenever r_valid is presented
  always @(negedge clk) begin
    resp_t r;
    if (periph_if.r_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got id %0d data %0h expected no response",
                 periph_if.r_id, periph_if.r_data);
      end else begin
        r = exp_q.pop_front();
        if (periph_if.r_data !== r.data || periph_if.r_id !== r.id) begin
          errors++;
          $display("FAIL resp got id %0d data %0h expected id %0d data %0h",
                   periph_if.r_id, periph_if.r_data, r.id, r.data);
        end
      end
    end else begin
      checks++;
      if (periph_if.r_data !== 32'd0 || periph_if.r_id !== '0) begin
        errors++;
        $display("FAIL resp_idle got id %0d data %0h expected 0 0", periph_if.r_id, periph_if.r_data);
      end
    end
  end

  initial begin
    logic [31:0] rd;
    bit es, ee, exp_g;
    int r;
    logic [5:0] w;

    periph_if.req  = 1'b0;
    periph_if.add  = 32'd0;
    periph_if.wen  = 1'b0;
    periph_if.be   = 4'd0;
    periph_if.data = 32'd0;
    periph_if.id   = '0;
    done           = 1'b0;
    rst_ni         = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", CFGW'(busy), CFGW'(0));
    check("rst_start", CFGW'(start), CFGW'(0));
    check("rst_evt", CFGW'(evt), CFGW'(0));
    check("rst_cfg", cfg, CFGW'(0));
    check("rst_rvalid", CFGW'(periph_if.r_valid), CFGW'(0));
    rst_ni = 1'b1;

    // Directed: job register writes, byte masking, unmapped read
    xact(32'h0000_0040, 1'b0, 4'hF, 32'hA5A5_1234, 1'b0);
    xact(32'h0000_0040, 1'b1, 4'hF, 32'h0, 1'b0);
    xact(32'h0000_0044, 1'b0, 4'h2, 32'hFFFF_FFFF, 1'b0);
    xact(32'h0000_0044, 1'b1, 4'h0, 32'h0, 1'b0);
    xact(32'h0000_0080, 1'b1, 4'h0, 32'h0, 1'b0);

    // Held request: grants alternate, one response per grant
    @(negedge clk);
    periph_if.req = 1'b1;
    periph_if.add = 32'h0000_0040;
    periph_if.wen = 1'b1;
    periph_if.id  = IDW'($urandom_range(0, 31));
    for (int c = 0; c < 3; c++) begin
      exp_g = (c != 1);
      #1;
      check("hold_gnt", CFGW'(periph_if.gnt), CFGW'(exp_g));
      if (exp_g) begin
        model_xact(periph_if.add, 1'b1, 4'h0, 32'h0, 1'b0, rd, es, ee);
        exp_q.push_back({periph_if.id, rd});
      end
      @(negedge clk);
    end
    periph_if.req = 1'b0;
    @(negedge clk);

    // Trigger, locked write, completion, status
    xact(32'h0000_0000, 1'b0, 4'hF, 32'h1, 1'b0);
    xact(32'h0000_0048, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    xact(32'h0000_0040, 1'b0, 4'hF, 32'h7, 1'b0);
    pulse_done();
    xact(32'h0000_0004, 1'b1, 4'h0, 32'h0, 1'b0);
    xact(32'h0000_0048, 1'b1, 4'h0, 32'h0, 1'b0);
    xact(32'h0000_0000, 1'b0, 4'hF, 32'h1, 1'b0);
    xact(32'h0000_0004, 1'b1, 4'h0, 32'h0, 1'b1);

    // Soft clear coinciding with done
    xact(32'h0000_0000, 1'b0, 4'h1, 32'h0, 1'b0);
    xact(32'h0000_0008, 1'b0, 4'hF, 32'h0, 1'b1);
    xact(32'h0000_0004, 1'b1, 4'h0, 32'h0, 1'b0);

    // Trigger with done in the same cycle while running, and done in IDLE
    xact(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b0);
    xact(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b1);
    pulse_done();

    // Counter saturation then clear
    for (int i = 0; i < CMAX + 1; i++) begin
      xact(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b0);
      pulse_done();
    end
    xact(32'h0000_000C, 1'b1, 4'h0, 32'h0, 1'b0);
    xact(32'h0000_0004, 1'b1, 4'h0, 32'h0, 1'b0);
    xact(32'h0000_000C, 1'b0, 4'hF, 32'h0, 1'b0);
    xact(32'h0000_000C, 1'b1, 4'h0, 32'h0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 19) begin
        pulse_done();
      end else begin
        if (r < 3) w = 6'd0;
        else if (r < 5) w = 6'd1;
        else if (r == 5) w = 6'd2;
        else if (r < 8) w = 6'd3;
        else if (r < 17) w = 6'(16 + $urandom_range(0, NJ + 1));
        else w = 6'($urandom_range(4, 63));
        xact({24'($urandom), w, 2'($urandom)}, 1'($urandom), 4'($urandom), $urandom,
             ($urandom_range(0, 3) == 0));
      end
    end

    // Reset while a job is running
    xact(32'h0000_0054, 1'b0, 4'hF, 32'h1234_5678, 1'b0);
    xact(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("midrst_busy", CFGW'(busy), CFGW'(0));
    check("midrst_cfg", cfg, CFGW'(0));
    check("midrst_evt", CFGW'(evt), CFGW'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    pulse_done();
    xact(32'h0000_0054, 1'b1, 4'h0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", CFGW'(exp_q.size()), CFGW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
